register_reader_serial: RTL
===========================

# register_reader_serial

Parallel-to-serial reader for the 32-bit register block: it captures the register's output word on a load handshake and streams it out one bit per accepted transfer over a valid/ready serial interface. It is the readout end of the register's parallel write path. Downstream serial consumers attach to it, and it supports back-pressure at every bit.

## Interface
- WIDTH, 32: word width in bits; legal range 2..64.
- LSB_FIRST, 0: 0 streams the MSB first, 1 streams the LSB first.

- clk  input  1  single clock; all state changes on its rising edge.
- clear_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  a word is offered on input_val.
- load_ready  output  1  the block can accept a word this cycle.
- input_val  input  WIDTH  parallel word; sampled only on a load accept.
- ser_data  output  1  current serial bit.
- ser_valid  output  1  ser_data holds a valid bit.
- ser_ready  input  1  the consumer accepts the current bit.
- ser_last  output  1  the current bit is the final bit of the word.
- busy  output  1  a word is in flight (state SHIFT).

## Operation
- States: IDLE and SHIFT. Reset enters IDLE.
- IDLE:
  - load_ready=1 and ser_valid=0.
  - A load accept (load_valid & load_ready) captures input_val into the shift register, clears the bit counter to 0 and moves to SHIFT.
- SHIFT:
  - load_ready=0 and ser_valid=1.
  - ser_data is the MSB of the shift register (LSB when LSB_FIRST=1).
  - A bit transfer occurs when ser_valid & ser_ready.
  - On a transfer, the shift register shifts one place toward the output end (zero fill) and the counter increments.
  - ser_last=1 exactly when the counter equals WIDTH-1.
  - A transfer with ser_last=1 returns the state to IDLE.
- The counter is ceil(log2(WIDTH)) bits wide and never wraps: it reaches at most WIDTH-1 before returning to IDLE.
- While in SHIFT, load_valid is ignored and input_val changes have no effect on the word in flight.
- With ser_ready held low, ser_data, ser_last and the counter stay stable indefinitely. There is no timeout.
- Reset asserted mid-word aborts the word. The partial stream is discarded and is not resumed after reset.
- busy equals (state == SHIFT).

## Timing
- Reset values, asynchronous on clear_n=0:
  - State IDLE.
  - load_ready=1, ser_valid=0, ser_data=0, ser_last=0, busy=0.
  - Counter 0, shift register 0.
- Load to first bit: ser_valid rises 1 cycle after the accept edge.
- Throughput:
  - With ser_ready held high, a word takes exactly WIDTH cycles in SHIFT.
  - One IDLE cycle (load_ready=1) follows each word, so back-to-back words cost WIDTH+1 cycles each.
- Last bit: the transfer with ser_last=1 occurs at edge N. At edge N+1 the block is in IDLE with load_ready=1, and a new load can be accepted at that edge.
- Outputs are registered or decoded from state only; there is no combinational path from any input to any output.

## Test plan
- Reset and idle: assert clear_n=0 mid-cycle, with no clock edge required.
  - Outputs go to load_ready=1, ser_valid=0, ser_data=0, ser_last=0 immediately.
- MSB-first stream: load 32'hA5000001 with ser_ready=1.
  - Bits appear as 1,0,1,0,0,1,0,1, then 23 zeros, then 1.
  - ser_last=1 only on bit 32.
  - ser_valid spans exactly 32 cycles.
  - load_ready returns to 1 on the next cycle.
- Back-pressure: load 32'h80000000, then toggle ser_ready 1,0,0,1,...
  - ser_data holds each bit across stall cycles.
  - The stream is 1 followed by 31 zeros, with no bit dropped or duplicated.
- LSB_FIRST=1, WIDTH=8: load 8'h81, then 8'h3C back-to-back with load_valid held high.
  - Stream is 1,0,0,0,0,0,0,1 and then 0,0,1,1,1,1,0,0.
  - Exactly one IDLE cycle separates the two words.
- Load ignored while busy: mid-word, drive load_valid=1 and change input_val to 32'hFFFFFFFF.
  - The in-flight word is unchanged and load_ready stays 0.
- Reset mid-word: pulse clear_n low after 10 bits of 32'h12345678.
  - The block returns to IDLE and no further ser_valid appears.
  - A new load of 32'h00000003 then streams 30 zeros followed by 1,1.

Source files
------------

// File: rtl/register_reader_serial.sv
// register_reader_serial
// Captures a parallel word on a load handshake and streams it out one bit
// per accepted transfer over a valid/ready serial interface. MSB first by
// default, LSB first when LSB_FIRST=1. All outputs decode from registers.
module register_reader_serial #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] input_val,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               xfer;

    // Outputs are decoded purely from registered state, never from inputs.
    always_comb begin
        load_ready = (state_q == ST_IDLE);
        ser_valid  = (state_q == ST_SHIFT);
        busy       = (state_q == ST_SHIFT);
        ser_last   = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
        ser_data   = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    end

    assign xfer = ser_valid & ser_ready;

    // Next-state logic: load in IDLE, shift one place per accepted bit in SHIFT.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    shreg_d = input_val;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (xfer) begin
                    // Zero fill toward the output end; a finished word leaves zeros behind.
                    shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
                    if (ser_last) begin
                        // Park the counter at 0 instead of letting it wrap past WIDTH-1.
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // State, shift register and bit counter; clear_n aborts any word in flight.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
